mup_poll_master: RTL and testbench
==================================

// Module: mup_poll_master
// PURPOSE
//  Parametrised half-duplex RS-485 poll master for MUP panels; successor to the fixed 2-TX/5-RX poller.
//  Transmits an address byte plus N_TX data bytes, turns the line around, then receives N_RX reply bytes.
//  Runs on the pult core clock, advancing one bit-tick per clk_en. Sits between the pult scan sequencer and the 485 driver.
// PARAMETERS
//  OVS      4   bit-ticks per serial bit (line baud = clk_en rate / OVS)
//  ADDR_W   3   MUP address width; address byte = {zeros, n_mup}, ADDR_W <= 8
//  N_TX     2   data bytes sent after the address byte (>= 1)
//  N_RX     5   reply bytes expected (>= 1)
//  TO_TICKS 64  reply-wait timeout and end-of-cycle guard time, in ticks
// PORTS
//  clk      in   1          core clock
//  rst      in   1          reset
//  clk_en   in   1          bit-tick enable; FSM, counters and input sync advance only when high
//  data_i   in   1          RS-485 receive line
//  data_o   out  1          RS-485 transmit line (idle 1)
//  dir_485  out  1          driver enable: 1 = transmit, 0 = receive
//  start    in   1          begin poll cycle (sampled on clk_en, ignored while busy)
//  n_mup    in   ADDR_W     target MUP address, latched at start
//  tx_data  in   8*N_TX     outgoing bytes, MS byte sent first, latched at start
//  rx_data  out  8*N_RX     received bytes, first byte into MS byte
//  busy     out  1          poll cycle in progress
//  answer   out  1          at least one reply byte received this cycle
//  error    out  1          parity error in any reply byte this cycle
//  timeout  out  1          reply byte missing within TO_TICKS
//  done     out  1          one-clk pulse (with clk_en) when cycle ends
// BEHAVIOUR
//  Reset: rst is synchronous, active-high; clock is clk. Reset: data_o=1, dir_485=0, busy=answer=error=timeout=done=0,
//   rx_data=0, state IDLE. rst mid-frame aborts immediately and takes priority over clk_en.
//  Frame (both directions): start 0, 8 data bits MSB first, parity = ^byte, stop 1; OVS ticks per bit; TX frame = 11*OVS ticks.
//  States: IDLE -> TX_BYTE (address, then N_TX data) -> WAIT_EDGE -> RX_BYTE -> WAIT_EDGE ... -> GUARD -> IDLE.
//  IDLE: start=1 latches n_mup and tx_data, sets busy=1, clears answer/error/timeout, sets dir_485=1, enters TX_BYTE next tick.
//  TX_BYTE: drives bits from a tick counter; after the last tick of the final stop bit, dir_485=0 in the same tick, go to WAIT_EDGE.
//  Input: data_i double-registered on clk_en; start edge = sync 1 -> 0.
//  WAIT_EDGE: counter cleared on entry; edge -> RX_BYTE with count=0; count reaches TO_TICKS-1 -> timeout=1, go to IDLE, done.
//  RX_BYTE: samples bit k (k=1..8) at count OVS*k, parity at OVS*9, then ends.
//   - Parity good: store the byte into rx_data slot.
//   - Parity bad: slot keeps its old value and error=1.
//   - answer=1 after first byte; more bytes -> WAIT_EDGE, else GUARD.
//  GUARD: dir_485=0, waits TO_TICKS ticks, then busy=0, done pulse, IDLE.
//  Timeout path: busy drops in the same tick that timeout is set.
//  answer/error/timeout hold until the next accepted start.
//  start with busy=1: ignored.
//  Glitch rule: a low that has returned high at the OVS/2 sample is a false start. Abandon the byte, return to WAIT_EDGE, keep the timeout count.
// CONFIGURATION
//  MUP_RETRY_EN defined: on timeout or any parity error, one automatic retry of the full cycle.
//   - Retry starts after GUARD, with the latched address and data.
//   - Flags are cleared at the retry start.
//   - Only the retry's result is reported, and done pulses once at the very end.
//  MUP_RETRY_EN undefined: no retry; flags report the single attempt.
// TESTING
//  OVS=4, n_mup=5, tx_data=16'hA53C, start -> line shows 8'h05 p0, 8'hA5 p0, 8'h3C p0; dir_485 falls after tick 131.
//  Model replies 5 good bytes 11,22,33,44,55 -> rx_data=40'h1122334455, answer=1, error=0, done after guard.
//  Third reply byte with flipped parity -> error=1, rx_data[23:16] keeps prior value, other bytes updated.
//  No reply -> timeout=1 exactly 64 ticks after turnaround, answer=0, busy=0; with MUP_RETRY_EN a second full frame appears.
//  rst asserted mid-TX -> next clk: data_o=1, dir_485=0, busy=0; start pulsed while busy -> ignored.
//  clk_en held low 10 clks mid-RX -> no state change; 2-clk low glitch on data_i -> no byte captured.

Source files
------------

// File: rtl/mup_poll_master.sv
// Half-duplex RS-485 poll master: address byte + N_TX data bytes out, then N_RX reply bytes in, one bit-tick per clk_en.
// Optional MUP_RETRY_EN: one automatic retry of the whole cycle after a timeout or reply parity error.
module mup_poll_master #(
    parameter int OVS      = 4,
    parameter int ADDR_W   = 3,
    parameter int N_TX     = 2,
    parameter int N_RX     = 5,
    parameter int TO_TICKS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                data_i,
    output logic                data_o,
    output logic                dir_485,
    // start is sampled on clk_en and accepted only while busy=0; busy stays high
    // until the cycle ends, which is marked by a single-clk done pulse.
    input  logic                start,
    input  logic [ADDR_W-1:0]   n_mup,
    input  logic [8*N_TX-1:0]   tx_data,
    output logic [8*N_RX-1:0]   rx_data,
    output logic                busy,
    output logic                answer,
    output logic                error,
    output logic                timeout,
    output logic                done
);
    localparam int SUB_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int TXI_W = $clog2(N_TX + 1);
    localparam int RXI_W = (N_RX > 1) ? $clog2(N_RX) : 1;
    localparam int TO_W  = $clog2(TO_TICKS + 1);

    typedef enum logic [2:0] {IDLE, TX_BYTE, WAIT_EDGE, RX_BYTE, GUARD} state_t;
    state_t state;

    logic [SUB_W-1:0]  sub_cnt;
    logic [3:0]        bit_cnt;
    logic [TXI_W-1:0]  tx_idx;
    logic [RXI_W-1:0]  rx_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [ADDR_W-1:0] addr_l;
    logic [8*N_TX-1:0] tx_l;
    logic [7:0]        rx_shift;
    logic              s1, s2, s3;
`ifdef MUP_RETRY_EN
    logic              retried;
`endif

    logic [7:0] tx_byte;
    logic [2:0] tx_sel;
    logic       tx_bit;
    logic       sub_last;
    logic       edge_seen;

    // Byte 0 of the TX sequence is the zero-extended address, then tx_data MS byte first.
    always_comb begin
        tx_byte = 8'(addr_l);
        for (int i = 1; i <= N_TX; i++) begin
            if (tx_idx == TXI_W'(i)) tx_byte = tx_l[8*(N_TX-i) +: 8];
        end
        tx_sel = 3'(4'd8 - bit_cnt);
        tx_bit = 1'b1;
        case (bit_cnt)
            4'd0:    tx_bit = 1'b0;
            4'd9:    tx_bit = ^tx_byte;
            4'd10:   tx_bit = 1'b1;
            default: tx_bit = tx_byte[tx_sel];
        endcase
    end

    assign sub_last  = (sub_cnt == SUB_W'(OVS - 1));
    assign edge_seen = s3 & ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_o   <= 1'b1;
            dir_485  <= 1'b0;
            busy     <= 1'b0;
            answer   <= 1'b0;
            error    <= 1'b0;
            timeout  <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sub_cnt  <= '0;
            bit_cnt  <= '0;
            tx_idx   <= '0;
            rx_idx   <= '0;
            to_cnt   <= '0;
            addr_l   <= '0;
            tx_l     <= '0;
            rx_shift <= '0;
            s1       <= 1'b1;
            s2       <= 1'b1;
            s3       <= 1'b1;
`ifdef MUP_RETRY_EN
            retried  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (clk_en) begin
                s1 <= data_i;
                s2 <= s1;
                s3 <= s2;
                case (state)
                    IDLE: begin
                        if (start) begin
                            addr_l  <= n_mup;
                            tx_l    <= tx_data;
                            busy    <= 1'b1;
                            answer  <= 1'b0;
                            error   <= 1'b0;
                            timeout <= 1'b0;
                            dir_485 <= 1'b1;
                            sub_cnt <= '0;
                            bit_cnt <= '0;
                            tx_idx  <= '0;
                            rx_idx  <= '0;
`ifdef MUP_RETRY_EN
                            retried <= 1'b0;
`endif
                            state   <= TX_BYTE;
                        end
                    end
                    TX_BYTE: begin
                        data_o <= tx_bit;
                        if (sub_last) begin
                            sub_cnt <= '0;
                            if (bit_cnt == 4'd10) begin
                                bit_cnt <= '0;
                                if (tx_idx == TXI_W'(N_TX)) begin
                                    dir_485 <= 1'b0;
                                    to_cnt  <= '0;
                                    state   <= WAIT_EDGE;
                                end else begin
                                    tx_idx <= tx_idx + TXI_W'(1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else begin
                            sub_cnt <= sub_cnt + SUB_W'(1);
                        end
                    end
                    WAIT_EDGE: begin
                        if (edge_seen) begin
                            sub_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= RX_BYTE;
                        end else if (to_cnt == TO_W'(TO_TICKS - 1)) begin
                            timeout <= 1'b1;
`ifdef MUP_RETRY_EN
                            if (!retried) begin
                                to_cnt <= '0;
                                state  <= GUARD;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
`endif
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    RX_BYTE: begin
                        if (sub_last) begin
                            sub_cnt <= '0;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else begin
                            sub_cnt <= sub_cnt + SUB_W'(1);
                        end
                        // Line back high mid start bit: false start, resume waiting with the timeout count intact.
                        if (bit_cnt == 4'd0 && sub_cnt == SUB_W'(OVS / 2) && s2) begin
                            state <= WAIT_EDGE;
                        end else if (sub_cnt == '0 && bit_cnt >= 4'd1 && bit_cnt <= 4'd8) begin
                            rx_shift <= {rx_shift[6:0], s2};
                        end else if (sub_cnt == '0 && bit_cnt == 4'd9) begin
                            answer <= 1'b1;
                            if ((^rx_shift) == s2) begin
                                for (int i = 0; i < N_RX; i++) begin
                                    if (rx_idx == RXI_W'(i)) rx_data[8*(N_RX-1-i) +: 8] <= rx_shift;
                                end
                            end else begin
                                error <= 1'b1;
                            end
                            to_cnt <= '0;
                            if (rx_idx == RXI_W'(N_RX - 1)) begin
                                state <= GUARD;
                            end else begin
                                rx_idx <= rx_idx + RXI_W'(1);
                                state  <= WAIT_EDGE;
                            end
                        end
                    end
                    GUARD: begin
                        if (to_cnt == TO_W'(TO_TICKS - 1)) begin
`ifdef MUP_RETRY_EN
                            if (!retried && (error || timeout)) begin
                                retried <= 1'b1;
                                answer  <= 1'b0;
                                error   <= 1'b0;
                                timeout <= 1'b0;
                                dir_485 <= 1'b1;
                                sub_cnt <= '0;
                                bit_cnt <= '0;
                                tx_idx  <= '0;
                                rx_idx  <= '0;
                                state   <= TX_BYTE;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= IDLE;
                            end
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
`endif
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mup_poll_master.sv
// Self-checking bench for mup_poll_master (default build): TX framing, replies, parity error, timeout, reset, stalls, glitches.
module tb_mup_poll_master;
    localparam int OVS      = 4;
    localparam int ADDR_W   = 3;
    localparam int N_TX     = 2;
    localparam int N_RX     = 5;
    localparam int TO_TICKS = 64;
    localparam int FRAME    = 11 * OVS;
    localparam int TX_TICKS = (N_TX + 1) * FRAME;

    logic              clk = 1'b0;
    logic              rst, clk_en, data_i, start;
    logic [ADDR_W-1:0] n_mup;
    logic [8*N_TX-1:0] tx_data;
    logic [8*N_RX-1:0] rx_data;
    logic              data_o, dir_485, busy, answer, error, timeout, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0]       exp_q[$];
    logic [8*N_RX-1:0] rx_exp_q[$];
    logic [8*N_RX-1:0] model_rx;
    logic              line_cap[TX_TICKS];
    logic              dir_cap[TX_TICKS];

    always #5 clk = ~clk;

    mup_poll_master #(.OVS(OVS), .ADDR_W(ADDR_W), .N_TX(N_TX), .N_RX(N_RX), .TO_TICKS(TO_TICKS)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .data_i(data_i), .data_o(data_o), .dir_485(dir_485),
        .start(start), .n_mup(n_mup), .tx_data(tx_data), .rx_data(rx_data), .busy(busy),
        .answer(answer), .error(error), .timeout(timeout), .done(done)
    );

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
        return {1'b0, b, ^b, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        data_i = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] addr, input logic [8*N_TX-1:0] data);
        exp_q.push_back(mk_frame(8'(addr)));
        for (int i = 0; i < N_TX; i++) exp_q.push_back(mk_frame(data[8*(N_TX-1-i) +: 8]));
        n_mup   = addr;
        tx_data = data;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic capture_tx(input int ignore_at);
        for (int i = 0; i < TX_TICKS; i++) begin
            if (i == ignore_at) begin
                start   = 1'b1;
                n_mup   = '1;
                tx_data = '1;
            end
            if (i == ignore_at + 2) start = 1'b0;
            tick();
            line_cap[i] = data_o;
            dir_cap[i]  = dir_485;
        end
        start = 1'b0;
    endtask

    task automatic check_tx_frames();
        logic [10:0] got, exp;
        for (int j = 0; j <= N_TX; j++) begin
            for (int b = 0; b < 11; b++) got[10-b] = line_cap[j*FRAME + b*OVS + OVS/2];
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_frame%0d: got %h expected <none queued>", j, got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL tx_frame%0d: got %h expected %h", j, got, exp);
                end
            end
        end
        check1("dir_before_turn", dir_cap[TX_TICKS-2], 1'b1);
        check1("dir_after_turn", dir_cap[TX_TICKS-1], 1'b0);
    endtask

    task automatic do_stall();
        logic [8*N_RX+5:0] snap;
        snap   = {rx_data, busy, answer, error, dir_485, data_o, done};
        clk_en = 1'b0;
        repeat (10) tick();
        clk_en = 1'b1;
        n_checks++;
        if ({rx_data, busy, answer, error, dir_485, data_o, done} !== snap) begin
            n_fail++;
            $display("FAIL clk_en_hold: got %h expected %h", {rx_data, busy, answer, error, dir_485, data_o, done}, snap);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad, input int stall_at);
        logic [10:0] bits;
        int idx;
        bits = {1'b0, b, (^b) ^ bad, 1'b1};
        idx  = 0;
        for (int k = 10; k >= 0; k--) begin
            for (int s = 0; s < OVS; s++) begin
                data_i = bits[k];
                if (idx == stall_at) do_stall();
                tick();
                idx++;
            end
        end
    endtask

    task automatic send_reply(input logic [8*N_RX-1:0] v, input int bad_slot, input int stall_at);
        for (int n = 0; n < N_RX; n++) begin
            if (n != bad_slot) model_rx[8*(N_RX-1-n) +: 8] = v[8*(N_RX-1-n) +: 8];
        end
        rx_exp_q.push_back(model_rx);
        for (int n = 0; n < N_RX; n++) begin
            send_byte(v[8*(N_RX-1-n) +: 8], n == bad_slot, (n == 0) ? stall_at : -1);
            idle(2);
        end
    endtask

    task automatic wait_done(input int limit);
        logic got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check1("done_seen", got, 1'b1);
    endtask

    task automatic check_result(input logic exp_answer, input logic exp_error);
        logic [8*N_RX-1:0] exp;
        n_checks++;
        if (rx_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_data: got %h expected <none queued>", rx_data);
        end else begin
            exp = rx_exp_q.pop_front();
            if (rx_data !== exp) begin
                n_fail++;
                $display("FAIL rx_data: got %h expected %h", rx_data, exp);
            end
        end
        check1("answer", answer, exp_answer);
        check1("error", error, exp_error);
        check1("timeout_clear", timeout, 1'b0);
        check1("busy_end", busy, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; data_i = 1'b1; start = 1'b0; n_mup = '0; tx_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        model_rx = '0;
        check1("rst_data_o", data_o, 1'b1);
        check1("rst_dir", dir_485, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_answer", answer, 1'b0);
        check1("rst_error", error, 1'b0);
        check1("rst_timeout", timeout, 1'b0);
        check1("rst_done", done, 1'b0);
        n_checks++;
        if (rx_data !== '0) begin
            n_fail++;
            $display("FAIL rst_rx_data: got %h expected 0", rx_data);
        end
    endtask

    task automatic test_poll_good();
        do_start(3'd5, 16'hA53C);
        check1("busy_at_start", busy, 1'b1);
        check1("dir_at_start", dir_485, 1'b1);
        capture_tx(20);
        check_tx_frames();
        idle(3);
        send_reply(40'h1122334455, -1, -1);
        wait_done(300);
        check_result(1'b1, 1'b0);
    endtask

    task automatic test_parity_error();
        logic [8*N_RX-1:0] v;
        v = 40'({$urandom(), $urandom()});
        v[23:16] = 8'hCC;
        do_start(3'd2, 16'($urandom_range(0, 65535)));
        capture_tx(-1);
        check_tx_frames();
        idle(3);
        send_reply(v, 2, -1);
        wait_done(300);
        check_result(1'b1, 1'b1);
    endtask

    task automatic test_no_reply();
        do_start(3'd7, 16'($urandom_range(0, 65535)));
        capture_tx(-1);
        check_tx_frames();
        data_i = 1'b1;
        repeat (TO_TICKS - 1) tick();
        check1("timeout_early", timeout, 1'b0);
        check1("busy_before_to", busy, 1'b1);
        tick();
        check1("timeout_set", timeout, 1'b1);
        check1("busy_at_to", busy, 1'b0);
        check1("done_at_to", done, 1'b1);
        check1("answer_at_to", answer, 1'b0);
        check1("error_cleared", error, 1'b0);
        n_checks++;
        if (rx_data !== model_rx) begin
            n_fail++;
            $display("FAIL rx_hold_on_to: got %h expected %h", rx_data, model_rx);
        end
        tick();
        check1("done_one_clk", done, 1'b0);
    endtask

    task automatic test_clk_en_hold();
        do_start(3'd3, 16'($urandom_range(0, 65535)));
        capture_tx(-1);
        check_tx_frames();
        idle(3);
        send_reply(40'({$urandom(), $urandom()}), -1, 14);
        wait_done(300);
        check_result(1'b1, 1'b0);
    endtask

    task automatic test_glitch();
        do_start(3'd1, 16'($urandom_range(0, 65535)));
        capture_tx(-1);
        check_tx_frames();
        idle(5);
        data_i = 1'b0;
        tick();
        tick();
        data_i = 1'b1;
        repeat (12) tick();
        check1("glitch_no_answer", answer, 1'b0);
        check1("glitch_busy", busy, 1'b1);
        send_reply(40'({$urandom(), $urandom()}), -1, -1);
        wait_done(300);
        check_result(1'b1, 1'b0);
    endtask

    task automatic test_rst_mid_tx();
        do_start(3'd4, 16'($urandom_range(0, 65535)));
        tick();
        tick();
        check1("pre_rst_data_o", data_o, 1'b0);
        check1("pre_rst_dir", dir_485, 1'b1);
        rst    = 1'b1;
        clk_en = 1'b0;
        tick();
        rst    = 1'b0;
        clk_en = 1'b1;
        exp_q.delete();
        model_rx = '0;
        check1("rst_mid_data_o", data_o, 1'b1);
        check1("rst_mid_dir", dir_485, 1'b0);
        check1("rst_mid_busy", busy, 1'b0);
        n_checks++;
        if (rx_data !== model_rx) begin
            n_fail++;
            $display("FAIL rst_mid_rx_data: got %h expected %h", rx_data, model_rx);
        end
    endtask

    initial begin
        test_reset();
        test_poll_good();
        test_parity_error();
        test_no_reply();
        test_clk_en_hold();
        test_glitch();
        test_rst_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
